kare_alma: RTL and testbench



---
 rtl/kare_pkg.sv | 14 +
 rtl/kare_alma_if.sv | 26 ++
 rtl/kare_adim.sv | 16 +
 rtl/kare_alma.sv | 106 ++++++++++
 tb/tb_kare_alma.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/kare_pkg.sv
// Shared types and default sizing for the sequential squarer (kare_alma)
// and its single-step helper.
package kare_pkg;

  typedef enum logic {
    BOSTA,
    HESAPLA
  } durum_t;

  localparam int GENISLIK_VARSAYILAN     = 32;
  localparam int TASMA_SINIRI_VARSAYILAN = 32;
  localparam int SAYAC_GENISLIGI         = $clog2(GENISLIK_VARSAYILAN);

endpackage : kare_pkg

// File: rtl/kare_alma_if.sv
// Start/result handshake bundle of the squarer: the operand and start request
// go in, and the registered square and status flags come back.
interface kare_alma_if
  import kare_pkg::*;
#(
  parameter int GENISLIK = GENISLIK_VARSAYILAN
);

  logic                    basla;
  logic [GENISLIK-1:0]     sayi;
  logic [2*GENISLIK-1:0]   sonuc;
  logic                    hazir;
  logic                    gecerli;
  logic                    tasma;

  modport master (
    output basla, sayi,
    input  sonuc, hazir, gecerli, tasma
  );

  modport slave (
    input  basla, sayi,
    output sonuc, hazir, gecerli, tasma
  );

endinterface : kare_alma_if

// File: rtl/kare_adim.sv
// One radix-2 shift-and-add step: conditionally add the shifted multiplicand
// to the accumulator. Kept standalone so a general multiplier can reuse it.
module kare_adim #(
  parameter int W = 64
) (
  input  logic [W-1:0] akumulator,
  input  logic [W-1:0] carpilan,
  input  logic         carpan_bit,
  output logic [W-1:0] sonraki
);

  always_comb begin
    sonraki = carpan_bit ? (akumulator + carpilan) : akumulator;
  end

endmodule : kare_adim

// File: rtl/kare_alma.sv
// Sequential unsigned squarer: sonuc = sayi * sayi over a fixed GENISLIK
// steps of shift-and-add, with a start/idle handshake and overflow flag.
module kare_alma
  import kare_pkg::*;
#(
  parameter int GENISLIK     = GENISLIK_VARSAYILAN,
  parameter int TASMA_SINIRI = TASMA_SINIRI_VARSAYILAN
) (
  input  logic        clk,
  input  logic        rst,
  kare_alma_if.slave  bus
);

  localparam int W  = 2 * GENISLIK;
  localparam int SW = (GENISLIK > 1) ? $clog2(GENISLIK) : 1;
  localparam logic [SW-1:0] SON_ADIM = SW'(GENISLIK - 1);

  durum_t              durum_q,    durum_d;
  logic [GENISLIK-1:0] carpan_q,   carpan_d;
  logic [W-1:0]        carpilan_q, carpilan_d;
  logic [W-1:0]        akum_q,     akum_d;
  logic [SW-1:0]       sayac_q,    sayac_d;
  logic [W-1:0]        sonuc_q,    sonuc_d;
  logic                gecerli_q,  gecerli_d;
  logic                tasma_q,    tasma_d;
  logic [W-1:0]        adim_sonraki;

  kare_adim #(.W(W)) u_adim (
    .akumulator (akum_q),
    .carpilan   (carpilan_q),
    .carpan_bit (carpan_q[0]),
    .sonraki    (adim_sonraki)
  );

  always_comb begin
    // NOTE: every variable gets a hold default first so no path infers a latch.
    durum_d    = durum_q;
    carpan_d   = carpan_q;
    carpilan_d = carpilan_q;
    akum_d     = akum_q;
    sayac_d    = sayac_q;
    sonuc_d    = sonuc_q;
    gecerli_d  = gecerli_q;
    tasma_d    = tasma_q;

    unique case (durum_q)
      BOSTA: begin
        if (bus.basla) begin
          carpan_d   = bus.sayi;
          carpilan_d = {{GENISLIK{1'b0}}, bus.sayi};
          akum_d     = '0;
          sayac_d    = '0;
          gecerli_d  = 1'b0;
          tasma_d    = 1'b0;
          durum_d    = HESAPLA;
        end
      end

      HESAPLA: begin
        akum_d     = adim_sonraki;
        carpilan_d = carpilan_q << 1;
        carpan_d   = carpan_q >> 1;
        sayac_d    = sayac_q + SW'(1);
        // Fixed latency: no early exit even once the multiplier runs out of ones.
        if (sayac_q == SON_ADIM) begin
          sonuc_d   = adim_sonraki;
          gecerli_d = 1'b1;
          tasma_d   = |(adim_sonraki >> TASMA_SINIRI);
          sayac_d   = '0;
          durum_d   = BOSTA;
        end
      end

      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all flops sample together.
    if (rst) begin
      durum_q    <= BOSTA;
      carpan_q   <= '0;
      carpilan_q <= '0;
      akum_q     <= '0;
      sayac_q    <= '0;
      sonuc_q    <= '0;
      gecerli_q  <= 1'b0;
      tasma_q    <= 1'b0;
    end else begin
      durum_q    <= durum_d;
      carpan_q   <= carpan_d;
      carpilan_q <= carpilan_d;
      akum_q     <= akum_d;
      sayac_q    <= sayac_d;
      sonuc_q    <= sonuc_d;
      gecerli_q  <= gecerli_d;
      tasma_q    <= tasma_d;
    end
  end

  assign bus.sonuc   = sonuc_q;
  assign bus.hazir   = (durum_q == BOSTA);
  assign bus.gecerli = gecerli_q;
  assign bus.tasma   = tasma_q;

endmodule : kare_alma

// File: tb/tb_kare_alma.sv
// Directed bench for kare_alma: a vector table of squares plus hand-written
// sequences for ignored starts, mid-run reset and back-to-back operation.
module tb_kare_alma;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  kare_alma_if #(.GENISLIK(32)) bus ();

  kare_alma #(.GENISLIK(32), .TASMA_SINIRI(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] sayi;
    logic [63:0] kare;
    logic        tasma;
  } vektor_t;

  int vektor_sayisi = 0;
  int hata_sayisi   = 0;

  task automatic check(input string ad, input logic [63:0] gercek, input logic [63:0] beklenen);
    vektor_sayisi++;
    if (gercek !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", ad, gercek, beklenen);
    end
  endtask

  // Start one operation and follow it until hazir returns (bounded).
  task automatic calis(input logic [31:0] x, output int mesgul,
                       output logic ilk_gecerli, output logic [63:0] ilk_sonuc);
    @(negedge clk);
    bus.basla = 1'b1;
    bus.sayi  = x;
    @(negedge clk);
    bus.basla   = 1'b0;
    bus.sayi    = $urandom;
    ilk_gecerli = bus.gecerli;
    ilk_sonuc   = bus.sonuc;
    mesgul = 0;
    while (!bus.hazir && mesgul < 100) begin
      mesgul++;
      @(negedge clk);
    end
  endtask

  vektor_t     tablo [7];
  int          mesgul;
  logic        ilk_gecerli;
  logic [63:0] ilk_sonuc;
  logic [63:0] onceki;

  initial begin
    tablo[0] = '{32'd0,          64'd0,                   1'b0};
    tablo[1] = '{32'd3,          64'd9,                   1'b0};
    tablo[2] = '{32'd65535,      64'h0000_0000_FFFE_0001, 1'b0};
    tablo[3] = '{32'd65536,      64'h0000_0001_0000_0000, 1'b1};
    tablo[4] = '{32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 1'b1};
    tablo[5] = '{32'd1000,       64'd1000000,             1'b0};
    tablo[6] = '{32'd46341,      64'd2147488281,          1'b0};

    rst       = 1'b1;
    bus.basla = 1'b0;
    bus.sayi  = '0;
    repeat (2) @(negedge clk);
    check("reset_sonuc",   bus.sonuc,   64'd0);
    check("reset_hazir",   bus.hazir,   64'd1);
    check("reset_gecerli", bus.gecerli, 64'd0);
    check("reset_tasma",   bus.tasma,   64'd0);
    rst = 1'b0;

    onceki = 64'd0;
    for (int i = 0; i < 7; i++) begin
      calis(tablo[i].sayi, mesgul, ilk_gecerli, ilk_sonuc);
      check($sformatf("v%0d_gecerli_dusus", i), ilk_gecerli, 64'd0);
      check($sformatf("v%0d_sonuc_korunur", i), ilk_sonuc, onceki);
      check($sformatf("v%0d_mesgul", i), 64'(mesgul), 64'd32);
      check($sformatf("v%0d_sonuc", i), bus.sonuc, tablo[i].kare);
      check($sformatf("v%0d_tasma", i), bus.tasma, 64'(tablo[i].tasma));
      check($sformatf("v%0d_gecerli", i), bus.gecerli, 64'd1);
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_tutma", i), bus.sonuc, tablo[i].kare);
      onceki = tablo[i].kare;
    end

    // Second start mid-run and a start on the completion edge are both ignored;
    // sayi churns every cycle while busy.
    @(negedge clk);
    bus.basla = 1'b1;
    bus.sayi  = 32'd5;
    @(negedge clk);
    bus.basla = 1'b0;
    mesgul = 0;
    while (!bus.hazir && mesgul < 100) begin
      mesgul++;
      bus.basla = (mesgul == 10) || (mesgul == 32);
      bus.sayi  = mesgul[0] ? 32'd7 : 32'hDEAD_BEEF;
      @(negedge clk);
    end
    bus.basla = 1'b0;
    check("yoksay_mesgul", 64'(mesgul), 64'd32);
    check("yoksay_sonuc",  bus.sonuc,   64'd25);
    @(negedge clk);
    check("yoksay_hazir_kalir", bus.hazir, 64'd1);
    check("yoksay_sonuc_kalir", bus.sonuc, 64'd25);

    // Reset at busy cycle 15 aborts the operation.
    @(negedge clk);
    bus.basla = 1'b1;
    bus.sayi  = 32'd1000;
    @(negedge clk);
    bus.basla = 1'b0;
    mesgul = 1;
    while (mesgul < 15) begin
      mesgul++;
      @(negedge clk);
    end
    check("rst_once_hazir", bus.hazir, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_sonuc",   bus.sonuc,   64'd0);
    check("rst_gecerli", bus.gecerli, 64'd0);
    check("rst_tasma",   bus.tasma,   64'd0);
    check("rst_hazir",   bus.hazir,   64'd1);
    calis(32'd12, mesgul, ilk_gecerli, ilk_sonuc);
    check("rst_sonra_mesgul", 64'(mesgul), 64'd32);
    check("rst_sonra_sonuc",  bus.sonuc,   64'd144);

    // Back-to-back with basla held: one result every 33 cycles.
    @(negedge clk);
    bus.basla = 1'b1;
    bus.sayi  = 32'd2;
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      mesgul = 0;
      while (!bus.gecerli && mesgul < 100) begin
        mesgul++;
        @(negedge clk);
      end
      check($sformatf("ardisik%0d_dusuk", r), 64'(mesgul), 64'd32);
      check($sformatf("ardisik%0d_sonuc", r), bus.sonuc, 64'd4);
      mesgul = 0;
      while (bus.gecerli && mesgul < 100) begin
        mesgul++;
        @(negedge clk);
      end
      check($sformatf("ardisik%0d_yuksek", r), 64'(mesgul), 64'd1);
    end
    bus.basla = 1'b0;
    mesgul = 0;
    while (!bus.hazir && mesgul < 100) begin
      mesgul++;
      @(negedge clk);
    end
    check("son_hazir", bus.hazir, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vektor_sayisi, hata_sayisi);
    $finish;
  end

endmodule : tb_kare_alma
